// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: circular instruction buffer between IF3 and decode.
// Optional zero-latency bypass when empty: define INST_BUF_BYPASS_EN.
module fetch_inst_buffer #(
    parameter int FETCH_W = 2,
    parameter int DEC_W   = 2,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [FETCH_W-1:0]         in_valid,
    input  logic [32*FETCH_W-1:0]      in_inst,
    input  logic [32*FETCH_W-1:0]      in_pc,
    output logic                       in_ready,
    output logic [DEC_W-1:0]           out_valid,
    output logic [32*DEC_W-1:0]        out_inst,
    output logic [32*DEC_W-1:0]        out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [31:0]        mem_inst [DEPTH];
    logic [31:0]        mem_pc   [DEPTH];

    logic [CW-1:0]      n_in;
    logic [CW-1:0]      n_out;
    logic [CW-1:0]      n_skip;
    logic [CW-1:0]      n_wr;
    logic [CW-1:0]      cnt_min;
    logic               run;
    logic               push;
    logic               pop;
    logic [FETCH_W-1:0] we;
    logic [PW-1:0]      waddr [FETCH_W];

    // Only the leading run of valid slots counts; later bits are ignored.
    always_comb begin
        n_in = '0;
        run  = 1'b1;
        for (int k = 0; k < FETCH_W; k++) begin
            run = run & in_valid[k];
            if (run) n_in = n_in + CW'(1);
        end
    end

    assign in_ready = (count <= CW'(DEPTH - FETCH_W));
    assign push     = in_ready && !flush;
    assign cnt_min  = (count < CW'(DEC_W)) ? count : CW'(DEC_W);

`ifdef INST_BUF_BYPASS_EN
    localparam int MW = (FETCH_W > DEC_W) ? FETCH_W : DEC_W;

    logic [32*MW-1:0] in_inst_pad;
    logic [32*MW-1:0] in_pc_pad;
    logic             byp;
    logic [CW-1:0]    n_byp;

    assign in_inst_pad = (32*MW)'(in_inst);
    assign in_pc_pad   = (32*MW)'(in_pc);
    assign byp         = (count == '0) && !flush;
    assign n_byp       = (n_in < CW'(DEC_W)) ? n_in : CW'(DEC_W);
    assign n_skip      = (byp && out_ready) ? n_byp : '0;

    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        for (int j = 0; j < DEC_W; j++) begin
            if (byp) begin
                out_valid[j]        = (CW'(j) < n_byp);
                out_inst[32*j +: 32] = in_inst_pad[32*j +: 32];
                out_pc[32*j +: 32]   = in_pc_pad[32*j +: 32];
            end else begin
                out_valid[j]        = (CW'(j) < count) && !flush;
                out_inst[32*j +: 32] = mem_inst[head + PW'(j)];
                out_pc[32*j +: 32]   = mem_pc[head + PW'(j)];
            end
        end
    end
`else
    assign n_skip = '0;

    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        for (int j = 0; j < DEC_W; j++) begin
            out_valid[j]        = (CW'(j) < count) && !flush;
            out_inst[32*j +: 32] = mem_inst[head + PW'(j)];
            out_pc[32*j +: 32]   = mem_pc[head + PW'(j)];
        end
    end
`endif

    // Bypassed slots never occupy an entry: remaining slots start at tail.
    assign pop   = out_ready && out_valid[0];
    assign n_out = pop ? cnt_min : '0;
    assign n_wr  = push ? (n_in - n_skip) : '0;

    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            we[k]    = push && (CW'(k) >= n_skip) && (CW'(k) < n_in);
            waddr[k] = tail + PW'(k) - PW'(n_skip);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_out);
            tail  <= tail + PW'(n_wr);
            count <= count + n_wr - n_out;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (we[k]) begin
                mem_inst[waddr[k]] <= in_inst[32*k +: 32];
                mem_pc[waddr[k]]   <= in_pc[32*k +: 32];
            end
        end
    end
endmodule

// File: tb/tb_fetch_inst_buffer.sv
// tb_fetch_inst_buffer: scoreboard bench for fetch_inst_buffer.
// Default build (INST_BUF_BYPASS_EN undefined), FETCH_W=DEC_W=2, DEPTH=16.
module tb_fetch_inst_buffer;
    localparam int FW    = 2;
    localparam int DW    = 2;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [FW-1:0] in_valid;
    logic [63:0]   in_inst;
    logic [63:0]   in_pc;
    logic          in_ready;
    logic [DW-1:0] out_valid;
    logic [63:0]   out_inst;
    logic [63:0]   out_pc;
    logic          out_ready;
    logic [4:0]    count;

    int            checks;
    int            errors;
    logic [31:0]   exp_q[$];
    logic [31:0]   next_pc;
    logic [31:0]   start_pc;

    fetch_inst_buffer #(
        .FETCH_W(FW),
        .DEC_W  (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_inst  (in_inst),
        .in_pc    (in_pc),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_inst (out_inst),
        .out_pc   (out_pc),
        .out_ready(out_ready),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hdead_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, compare against the model, advance the model.
    task automatic cycle(input logic fl, input logic [1:0] iv,
                         input logic ordy);
        int         nin;
        int         nv;
        logic       rdy;
        logic [1:0] vmask;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_pc     = {next_pc + 32'd4, next_pc};
        in_inst   = {inst_of(next_pc + 32'd4), inst_of(next_pc)};
        #1;
        nin   = iv[0] ? (iv[1] ? 2 : 1) : 0;
        rdy   = (DEPTH - exp_q.size()) >= FW;
        nv    = fl ? 0 : ((exp_q.size() < DW) ? exp_q.size() : DW);
        vmask = 2'((1 << nv) - 1);
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("out_valid", 64'(out_valid), 64'(vmask));
        check("count", 64'(count), 64'(exp_q.size()));
        for (int j = 0; j < nv; j++) begin
            check("out_pc", 64'(out_pc[32*j +: 32]), 64'(exp_q[j]));
            check("out_inst", 64'(out_inst[32*j +: 32]),
                  64'(inst_of(exp_q[j])));
        end
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (ordy) repeat (nv) void'(exp_q.pop_front());
            if (rdy) begin
                for (int k = 0; k < nin; k++)
                    exp_q.push_back(next_pc + 32'(4 * k));
                next_pc = next_pc + 32'(4 * nin);
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && exp_q.size() > 0; c++)
            cycle(1'b0, 2'b00, 1'b1);
        check("drained", 64'(exp_q.size()), 64'd0);
        cycle(1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        next_pc   = 32'h1000;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = '0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        #3;
        check("rst0_count", 64'(count), 64'd0);
        check("rst0_in_ready", 64'(in_ready), 64'd1);
        check("rst0_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // basic push
        cycle(1'b0, 2'b11, 1'b0);
        cycle(1'b0, 2'b00, 1'b0);
        check("basic_pc", 64'(out_pc), 64'h0000_1004_0000_1000);
        drain();

        // fill to full, then hold input while full
        for (int i = 0; i < 8; i++) cycle(1'b0, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b11, 1'b0);
        check("full_count", 64'(count), 64'd16);
        drain();

        // wrap ordering with random decode back-pressure
        start_pc = next_pc;
        for (int c = 0; c < 200 && next_pc < start_pc + 32'd160; c++)
            cycle(1'b0, 2'b11, 1'($urandom_range(0, 1)));
        drain();

        // flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b11, 1'b0);
        cycle(1'b1, 2'b11, 1'b1);
        cycle(1'b0, 2'b11, 1'b0);
        cycle(1'b0, 2'b00, 1'b0);
        drain();

        // non-contiguous valid
        cycle(1'b0, 2'b01, 1'b0);
        cycle(1'b0, 2'b10, 1'b0);
        cycle(1'b0, 2'b00, 1'b0);
        drain();

        // asynchronous reset mid-stream at count=5
        cycle(1'b0, 2'b11, 1'b0);
        cycle(1'b0, 2'b11, 1'b0);
        cycle(1'b0, 2'b01, 1'b0);
        check("pre_rst_count", 64'(count), 64'd5);
        in_valid = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b0, 2'b00, 1'b0);
        cycle(1'b0, 2'b11, 1'b1);
        cycle(1'b0, 2'b00, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
